fsm_ab_initiator: RTL and testbench

// - Initiator end of the two-input (a,b) / two-flag (y0,y1) FSM handshake: drives a,b into the responder FSM, checks y0 (Mealy ack) and y1 (Moore ready).
// - Turns queued commands (FIRE, ARM) into the exact a/b cycle sequences the responder expects.
// - Keeps a shadow of the responder state, flags protocol violations and counts completed commands.

---
 rtl/fsm_ab_pkg.sv | 46 ++++
 rtl/ab_cycle_counter.sv | 27 ++
 rtl/fsm_ab_initiator.sv | 157 +++++++++++++++
 tb/tb_fsm_ab_initiator.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_ab_pkg.sv
// Shared types and decode helpers for the a/b initiator and its responder shadow.
package fsm_ab_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        GAP,
        ARM,
        HOLD,
        RELEASE,
        ERR
    } init_state_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2
    } resp_state_t;

    localparam logic OP_FIRE = 1'b0;
    localparam logic OP_ARM  = 1'b1;

    // {a,b} driven while sitting in a given initiator state
    function automatic logic [1:0] ab_of(input init_state_t s);
        case (s)
            FIRE:         ab_of = 2'b11;
            ARM, RELEASE: ab_of = 2'b10;
            default:      ab_of = 2'b00;
        endcase
    endfunction

    // Responder state implied by the initiator state
    function automatic resp_state_t shadow_of(input init_state_t s);
        case (s)
            GAP:           shadow_of = S2;
            HOLD, RELEASE: shadow_of = S1;
            default:       shadow_of = S0;
        endcase
    endfunction

    // Moore ready the responder presents in a given state
    function automatic logic ready_of(input resp_state_t r);
        ready_of = (r == S0) || (r == S1);
    endfunction

endpackage

// File: rtl/ab_cycle_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag.
module ab_cycle_counter #(
    parameter int unsigned W        = 4,
    parameter int unsigned TERMINAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc_c = (cnt == W'(TERMINAL));

endmodule

// File: rtl/fsm_ab_initiator.sv
// Initiator side of the a/b -> y0/y1 handshake: sequences FIRE/ARM commands,
// checks the responder flags against a shadow of its state, counts completions.
module fsm_ab_initiator
    import fsm_ab_pkg::*;
#(
    parameter int unsigned HOLD_CYC    = 3,
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic             cmd_op,
    output logic             cmd_ready,
    output logic             a,
    output logic             b,
    input  logic             y0,
    input  logic             y1,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam int unsigned HCNT_W = $clog2(HOLD_CYC) + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC) + 1;

    init_state_t state;
    init_state_t next_state;
    resp_state_t shadow;
    logic        y1_exp;
    logic        complete;
    logic        h_clr;
    logic        h_en;
    logic        h_tc_c;
    logic        t_clr;
    logic        t_en;
    logic        t_tc_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign cmd_ready = (state == IDLE) && y1 && !err;
    assign y1_exp    = ready_of(shadow);

    // Next-state and protocol checks; flags are sampled in the cycle the state drives a/b
    always_comb begin
        next_state = state;
        complete   = 1'b0;
        h_clr      = 1'b1;
        h_en       = 1'b0;
        t_clr      = 1'b1;
        t_en       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    case (cmd_op)
                        OP_FIRE: next_state = FIRE;
                        OP_ARM:  next_state = ARM;
                        default: next_state = FIRE;
                    endcase
                end else if (cmd_valid && !y1) begin
                    t_clr = 1'b0;
                    t_en  = 1'b1;
                    if (t_tc_c) begin
                        next_state = ERR;
                    end
                end
            end
            FIRE: begin
                next_state = (y0 && (y1 == y1_exp)) ? GAP : ERR;
            end
            GAP: begin
                if (y1 == y1_exp) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else begin
                    next_state = ERR;
                end
            end
            ARM: begin
                next_state = (!y0 && (y1 == y1_exp)) ? HOLD : ERR;
            end
            HOLD: begin
                h_clr = 1'b0;
                h_en  = 1'b1;
                if (y1 != y1_exp) begin
                    next_state = ERR;
                end else if (h_tc_c) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (!y0 && (y1 == y1_exp)) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else begin
                    next_state = ERR;
                end
            end
            ERR: begin
                next_state = ERR;
            end
            default: begin
                next_state = ERR;
            end
        endcase
    end

    ab_cycle_counter #(
        .W        (HCNT_W),
        .TERMINAL (HOLD_CYC - 1)
    ) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (h_clr),
        .en   (h_en),
        .tc_c (h_tc_c)
    );

    ab_cycle_counter #(
        .W        (TCNT_W),
        .TERMINAL (TIMEOUT_CYC - 1)
    ) u_timeout_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (t_clr),
        .en   (t_en),
        .tc_c (t_tc_c)
    );

    // Output decode, registered from next_state so a/b always match the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= 1'b0;
            b       <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            txn_cnt <= '0;
            shadow  <= S0;
        end else begin
            {a, b}  <= ab_of(next_state);
            shadow  <= shadow_of(next_state);
            done    <= complete;
            err     <= err | (next_state == ERR);
            if (complete) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fsm_ab_initiator.sv
// Bench for fsm_ab_initiator paired with a behavioural responder FSM;
// completions are checked by a scoreboard monitor on the done pulse.
module tb_fsm_ab_initiator;
    import fsm_ab_pkg::*;

    localparam int unsigned HOLD_CYC    = 3;
    localparam int unsigned TIMEOUT_CYC = 15;
    localparam int unsigned CNT_W       = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_op = 1'b0;
    logic             cmd_ready;
    logic             a;
    logic             b;
    logic             y0;
    logic             y1;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] txn_cnt;

    resp_state_t rs;
    logic y0_frc = 1'b0;
    logic y0_val = 1'b0;
    logic y1_frc = 1'b0;
    logic y1_val = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t sb[$];

    fsm_ab_initiator #(
        .HOLD_CYC    (HOLD_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .a         (a),
        .b         (b),
        .y0        (y0),
        .y1        (y1),
        .done      (done),
        .err       (err),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: S0 -11-> S2 -00-> S0, S0 -10-> S1 -10-> S0
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rs <= S0;
        end else begin
            case (rs)
                S0:      if (a && b) rs <= S2; else if (a && !b) rs <= S1;
                S1:      if (a && !b) rs <= S0;
                S2:      if (!a && !b) rs <= S0;
                default: rs <= S0;
            endcase
        end
    end

    assign y0 = y0_frc ? y0_val : ((rs == S0) && a && b);
    assign y1 = y1_frc ? y1_val : ((rs == S0) || (rs == S1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("done_txn_cnt", 32'(txn_cnt), e.cnt);
                chk("done_err", 32'(err), 32'd0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        chk("pending_done_before_reset", sb.size(), 0);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        y0_frc    = 1'b0;
        y1_frc    = 1'b0;
        tick();
        tick();
        chk("rst_ab", 32'({a, b}), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
    endtask

    // Present one command for one cycle; leaves the bench at the first cycle after accept
    task automatic issue(input logic op, input int lat, input int cnt, input bit exp_done);
        exp_t e;
        chk("ready_at_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        if (exp_done) begin
            e.cyc = cyc + lat;
            e.cnt = cnt;
            sb.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] ab_exp [5];
        exp_t e;
        ab_exp = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};

        // Single FIRE
        do_reset();
        issue(OP_FIRE, 3, 1, 1'b1);
        chk("fire_c1_ab", 32'({a, b}), 32'h3);
        chk("fire_c1_y0", 32'(y0), 32'd1);
        chk("fire_c1_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("fire_c2_ab", 32'({a, b}), 32'h0);
        chk("fire_c2_y1", 32'(y1), 32'd0);
        tick();
        chk("fire_c3_done", 32'(done), 32'd1);
        chk("fire_c3_err", 32'(err), 32'd0);
        tick();

        // Single ARM
        do_reset();
        issue(OP_ARM, int'(HOLD_CYC) + 3, 1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            chk("arm_ab_seq", 32'({a, b}), 32'(ab_exp[i]));
            chk("arm_y1", 32'(y1), 32'd1);
        end
        tick();
        chk("arm_c6_done", 32'(done), 32'd1);
        tick();

        // Back-to-back FIREs with cmd_valid held
        do_reset();
        chk("b2b_ready0", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_FIRE;
        for (int k = 1; k <= 3; k++) begin
            e.cyc = cyc + 3 * k;
            e.cnt = k;
            sb.push_back(e);
        end
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("b2b_ready", 32'(cmd_ready), 32'((i % 3) == 0));
            if (i == 9) cmd_valid = 1'b0;
        end
        tick();
        chk("b2b_ab_idle", 32'({a, b}), 32'h0);
        chk("b2b_txn_cnt", 32'(txn_cnt), 32'd3);
        chk("b2b_err", 32'(err), 32'd0);

        // Missing y0 during FIRE
        do_reset();
        y0_frc = 1'b1;
        y0_val = 1'b0;
        issue(OP_FIRE, 0, 0, 1'b0);
        chk("y0err_c1_err", 32'(err), 32'd0);
        chk("y0err_c1_ab", 32'({a, b}), 32'h3);
        tick();
        chk("y0err_c2_err", 32'(err), 32'd1);
        chk("y0err_c2_ab", 32'({a, b}), 32'h0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("y0err_ready", 32'(cmd_ready), 32'd0);
            chk("y0err_done", 32'(done), 32'd0);
            chk("y0err_sticky", 32'(err), 32'd1);
            chk("y0err_ab", 32'({a, b}), 32'h0);
        end
        cmd_valid = 1'b0;
        y0_frc    = 1'b0;

        // Timeout while y1 stays low
        do_reset();
        y1_frc    = 1'b1;
        y1_val    = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 1; i <= int'(TIMEOUT_CYC); i++) begin
            tick();
            chk("timeout_err", 32'(err), 32'(i >= int'(TIMEOUT_CYC)));
        end
        chk("timeout_ab", 32'({a, b}), 32'h0);
        cmd_valid = 1'b0;
        y1_frc    = 1'b0;

        // Counter wrap, then reset in the middle of HOLD
        do_reset();
        cmd_valid = 1'b1;
        cmd_op    = OP_FIRE;
        for (int k = 1; k <= 5; k++) begin
            e.cyc = cyc + 3 * k;
            e.cnt = k % 4;
            sb.push_back(e);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 15) cmd_valid = 1'b0;
        end
        tick();
        chk("wrap_txn_cnt", 32'(txn_cnt), 32'd1);
        issue(OP_ARM, 0, 0, 1'b0);
        tick();
        tick();
        chk("hold2_state", 32'(dut.state), 32'(HOLD));
        rst = 1'b1;
        #1;
        chk("midrst_ab", 32'({a, b}), 32'h0);
        chk("midrst_state", 32'(dut.state), 32'(IDLE));
        chk("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_no_done", 32'(done), 32'd0);
            chk("midrst_idle_ab", 32'({a, b}), 32'h0);
        end

        chk("pending_done_at_end", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
